// File: rtl/ldl_round_pkg.sv
// ldl_round_pkg: shared constants, FSM state type and helpers for the
// round-library arbiters.
//   MAX_REQ    - largest supported requester count
//   MAX_WGT_W  - widest weight field eff_weight() can carry
//   state_e    - handshake FSM states of ldl_round_wrr
//   eff_weight - maps a raw weight field to the beat budget actually used
//   wrap_inc   - index increment modulo an arbitrary (non-power-of-two) count
package ldl_round_pkg;

  localparam int MAX_REQ   = 256;
  localparam int MAX_WGT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,    // no grant outstanding
    ST_GRANT,   // granted, more beats left in the budget
    ST_LAST,    // granted, current beat exhausts the budget
    ST_LOCKED   // grant held by lock, budget ignored
  } state_e;

  // A zero weight would starve its requester, so it is promoted to one beat.
  // In plain round-robin mode every grant is exactly one beat.
  function automatic logic [MAX_WGT_W-1:0] eff_weight(
    input logic [MAX_WGT_W-1:0] raw,
    input logic                 mode
  );
    if (!mode || raw == '0) return MAX_WGT_W'(1);
    return raw;
  endfunction

  function automatic int unsigned wrap_inc(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ldl_round_wrr_pick.sv
// ldl_round_wrr_pick: combinational rotating-priority picker.
//   c     in  REQ_WIDTH  candidate vector
//   start in  BIN_WIDTH  highest-priority index (must be < REQ_WIDTH)
//   hit   out 1          at least one candidate is set
//   index out BIN_WIDTH  first set candidate at or after start, wrapping
// The candidate vector is duplicated and shifted down by start so that a
// plain lowest-bit priority encoder sees the rotated order; the offset is
// then added back modulo REQ_WIDTH, which keeps non-power-of-two counts
// from ever producing an index past the last requester.
module ldl_round_wrr_pick
  import ldl_round_pkg::*;
#(
  parameter int REQ_WIDTH = 8,
  parameter int BIN_WIDTH = $clog2(REQ_WIDTH)
) (
  input  logic [REQ_WIDTH-1:0] c,
  input  logic [BIN_WIDTH-1:0] start,
  output logic                 hit,
  output logic [BIN_WIDTH-1:0] index
);

  logic [2*REQ_WIDTH-1:0] dbl;
  logic [2*REQ_WIDTH-1:0] rot;
  logic [REQ_WIDTH-1:0]   low;
  logic [BIN_WIDTH-1:0]   offs;
  logic [BIN_WIDTH:0]     sum;

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    dbl  = {c, c};
    rot  = dbl >> start;
    low  = rot[REQ_WIDTH-1:0];
    hit  = |low;
    offs = '0;
    for (int i = REQ_WIDTH - 1; i >= 0; i--) begin
      if (low[i]) offs = BIN_WIDTH'(i);
    end
    sum = {1'b0, start} + {1'b0, offs};
    if (sum >= (BIN_WIDTH + 1)'(REQ_WIDTH)) sum = sum - (BIN_WIDTH + 1)'(REQ_WIDTH);
    index = sum[BIN_WIDTH-1:0];
  end

endmodule

// File: rtl/ldl_round_wrr.sv
// ldl_round_wrr: registered weighted round-robin arbiter with a valid/ready
// grant interface.
//   clk    in  1                     rising-edge clock
//   rst    in  1                     synchronous reset, active-high
//   req    in  REQ_WIDTH             level-sensitive requests
//   en     in  REQ_WIDTH             per-requester enable for arbitration
//   weight in  REQ_WIDTH*WGT_WIDTH   flat per-requester beat budgets
//   lock   in  1                     hold current grant on handshake
//   ready  in  1                     consumer accepts current beat
//   valid  out 1                     grant valid
//   hot    out REQ_WIDTH             one-hot grant, zero when idle
//   bin    out BIN_WIDTH             encoded grant, holds when idle
//   last   out 1                     current beat ends this grant's budget
// A grant is kept while its requester stays requesting and enabled and either
// lock is high or budget remains; otherwise the picker searches from bin+1
// with bin itself lowest priority. Nothing moves while valid & ~ready, so a
// presented grant is never withdrawn.
module ldl_round_wrr
  import ldl_round_pkg::*;
#(
  parameter int REQ_WIDTH = 8,
  parameter int BIN_WIDTH = $clog2(REQ_WIDTH),
  parameter int WGT_WIDTH = 4,
  parameter int MODE      = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQ_WIDTH-1:0]           req,
  input  logic [REQ_WIDTH-1:0]           en,
  input  logic [REQ_WIDTH*WGT_WIDTH-1:0] weight,
  input  logic                           lock,
  input  logic                           ready,
  output logic                           valid,
  output logic [REQ_WIDTH-1:0]           hot,
  output logic [BIN_WIDTH-1:0]           bin,
  output logic                           last
);

  state_e                 state_q, state_d;
  logic [BIN_WIDTH-1:0]   bin_q,   bin_d;
  logic [WGT_WIDTH-1:0]   cnt_q,   cnt_d;
  logic [WGT_WIDTH-1:0]   wq_q,    wq_d;

  logic [BIN_WIDTH-1:0]   start;
  logic                   pick_hit;
  logic [BIN_WIDTH-1:0]   pick_idx;
  logic [WGT_WIDTH:0]     cnt_inc;
  logic                   below_budget;
  logic                   upd;
  logic                   keep;
  logic [MAX_WGT_W-1:0]   raw_w;
  logic [WGT_WIDTH-1:0]   wq_pick;
  logic [WGT_WIDTH:0]     next_inc;

  assign valid = (state_q != ST_IDLE);
  assign start = BIN_WIDTH'(wrap_inc(32'(bin_q), REQ_WIDTH));

  ldl_round_wrr_pick #(
    .REQ_WIDTH (REQ_WIDTH),
    .BIN_WIDTH (BIN_WIDTH)
  ) u_pick (
    .c     (req & en),
    .start (start),
    .hit   (pick_hit),
    .index (pick_idx)
  );

  // One extra bit so cnt + 1 cannot wrap before the budget compare.
  assign cnt_inc      = {1'b0, cnt_q} + 1'b1;
  assign below_budget = cnt_inc < {1'b0, wq_q};
  assign upd          = ~valid | ready;
  assign keep         = valid & ready & req[bin_q] & en[bin_q] & (lock | below_budget);

  always_comb begin
    raw_w                  = '0;
    raw_w[WGT_WIDTH-1:0]   = weight[int'(pick_idx)*WGT_WIDTH +: WGT_WIDTH];
    wq_pick                = WGT_WIDTH'(eff_weight(raw_w, MODE != 0));
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    wq_d     = wq_q;
    next_inc = '0;
    if (upd) begin
      if (keep) begin
        // Under lock the counter saturates instead of wrapping, so a long
        // locked packet cannot fake an early budget-exhausted beat.
        if (lock && cnt_q == '1) cnt_d = cnt_q;
        else                     cnt_d = cnt_q + 1'b1;
        next_inc = {1'b0, cnt_d} + 1'b1;
        if (lock)                        state_d = ST_LOCKED;
        else if (next_inc >= {1'b0, wq_q}) state_d = ST_LAST;
        else                             state_d = ST_GRANT;
      end else if (pick_hit) begin
        bin_d   = pick_idx;
        cnt_d   = '0;
        wq_d    = wq_pick;
        state_d = (wq_pick == WGT_WIDTH'(1)) ? ST_LAST : ST_GRANT;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      cnt_q   <= '0;
      wq_q    <= WGT_WIDTH'(1);
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      wq_q    <= wq_d;
    end
  end

  always_comb begin
    hot = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      hot[i] = valid && (bin_q == BIN_WIDTH'(i));
    end
  end

  assign bin  = bin_q;
  assign last = valid & ~lock & ~below_budget;

endmodule

// File: tb/tb_ldl_round_wrr.sv
module tb_ldl_round_wrr;

  logic        clk;
  logic        rst;

  logic [3:0]  req4, en4, hot4;
  logic [15:0] weight4;
  logic        lock4, ready4, valid4, last4;
  logic [1:0]  bin4;

  logic [4:0]  req5, en5, hot5;
  logic [19:0] weight5;
  logic        lock5, ready5, valid5, last5;
  logic [2:0]  bin5;

  int checks;
  int failures;

  ldl_round_wrr #(.REQ_WIDTH(4), .WGT_WIDTH(4), .MODE(1)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .en(en4), .weight(weight4),
    .lock(lock4), .ready(ready4), .valid(valid4), .hot(hot4),
    .bin(bin4), .last(last4)
  );

  ldl_round_wrr #(.REQ_WIDTH(5), .WGT_WIDTH(4), .MODE(0)) dut5 (
    .clk(clk), .rst(rst), .req(req5), .en(en5), .weight(weight5),
    .lock(lock5), .ready(ready5), .valid(valid5), .hot(hot5),
    .bin(bin5), .last(last5)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req4 = '0; en4 = '0; weight4 = '0; lock4 = 0; ready4 = 0;
    req5 = '0; en5 = '0; weight5 = '0; lock5 = 0; ready5 = 0;
    do_reset();
    checks++; if (valid4 !== 1'b0) begin failures++; $display("FAIL reset_valid4 got=%b exp=0", valid4); end
    checks++; if (bin4 !== 2'd0) begin failures++; $display("FAIL reset_bin4 got=%0d exp=0", bin4); end
    checks++; if (hot4 !== 4'b0) begin failures++; $display("FAIL reset_hot4 got=%b exp=0000", hot4); end
    checks++; if (last4 !== 1'b0) begin failures++; $display("FAIL reset_last4 got=%b exp=0", last4); end
    checks++; if (valid5 !== 1'b0 || bin5 !== 3'd0) begin failures++; $display("FAIL reset_dut5 got valid=%b bin=%0d exp 0/0", valid5, bin5); end
  endtask

  task automatic test_weighted_rotation();
    int exp_bin [8] = '{1, 1, 2, 2, 2, 3, 0, 1};
    bit exp_last[8] = '{0, 1, 0, 0, 1, 1, 1, 0};
    logic [3:0] exp_hot;
    do_reset();
    weight4 = 16'h1320;  // w3=1 w2=3 w1=2 w0=0
    req4 = 4'b1111; en4 = 4'b1111; ready4 = 1; lock4 = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_hot = 4'b0001 << exp_bin[i];
      checks++; if (valid4 !== 1'b1 || bin4 !== 2'(exp_bin[i])) begin
        failures++; $display("FAIL rot_bin beat=%0d got valid=%b bin=%0d exp valid=1 bin=%0d", i, valid4, bin4, exp_bin[i]); end
      checks++; if (last4 !== exp_last[i]) begin
        failures++; $display("FAIL rot_last beat=%0d got=%b exp=%b", i, last4, exp_last[i]); end
      checks++; if (hot4 !== exp_hot) begin
        failures++; $display("FAIL rot_hot beat=%0d got=%b exp=%b", i, hot4, exp_hot); end
    end
  endtask

  task automatic test_backpressure();
    bit exp_last[5] = '{0, 1, 0, 0, 1};
    do_reset();
    weight4 = 16'h1320;  // w2=3
    req4 = 4'b0100; en4 = 4'b1111; ready4 = 1; lock4 = 0;
    step();
    checks++; if (valid4 !== 1'b1 || bin4 !== 2'd2 || last4 !== 1'b0) begin
      failures++; $display("FAIL bp_first got valid=%b bin=%0d last=%b exp 1/2/0", valid4, bin4, last4); end
    ready4 = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req4 = 4'b0000;  // request drop while stalled must not withdraw
      if (i == 3) req4 = 4'b0100;
      step();
      checks++; if (valid4 !== 1'b1 || bin4 !== 2'd2 || last4 !== 1'b0) begin
        failures++; $display("FAIL bp_hold cyc=%0d got valid=%b bin=%0d last=%b exp 1/2/0", i, valid4, bin4, last4); end
    end
    ready4 = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (valid4 !== 1'b1 || bin4 !== 2'd2 || last4 !== exp_last[i]) begin
        failures++; $display("FAIL bp_drain beat=%0d got valid=%b bin=%0d last=%b exp 1/2/%b", i, valid4, bin4, last4, exp_last[i]); end
    end
  endtask

  task automatic test_lock();
    do_reset();
    weight4 = 16'h1321;  // w0=1 w1=2
    req4 = 4'b0001; en4 = 4'b1111; ready4 = 1; lock4 = 0;
    step();
    checks++; if (valid4 !== 1'b1 || bin4 !== 2'd0 || last4 !== 1'b1) begin
      failures++; $display("FAIL lock_first got valid=%b bin=%0d last=%b exp 1/0/1", valid4, bin4, last4); end
    req4 = 4'b0011; lock4 = 1;
    #1;
    checks++; if (last4 !== 1'b0) begin
      failures++; $display("FAIL lock_last_comb got=%b exp=0", last4); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (valid4 !== 1'b1 || bin4 !== 2'd0 || last4 !== 1'b0) begin
        failures++; $display("FAIL lock_hold beat=%0d got valid=%b bin=%0d last=%b exp 1/0/0", i, valid4, bin4, last4); end
    end
    lock4 = 0;
    #1;
    checks++; if (last4 !== 1'b1) begin
      failures++; $display("FAIL lock_release_last got=%b exp=1", last4); end
    step();
    checks++; if (valid4 !== 1'b1 || bin4 !== 2'd1 || last4 !== 1'b0) begin
      failures++; $display("FAIL lock_rotate got valid=%b bin=%0d last=%b exp 1/1/0", valid4, bin4, last4); end
  endtask

  task automatic test_mask_drop();
    do_reset();
    weight4 = 16'h0040;  // w1=4, others act as 1
    req4 = 4'b0111; en4 = 4'b1111; ready4 = 1; lock4 = 0;
    step();
    checks++; if (bin4 !== 2'd1 || last4 !== 1'b0) begin
      failures++; $display("FAIL mask_beat1 got bin=%0d last=%b exp 1/0", bin4, last4); end
    step();
    checks++; if (bin4 !== 2'd1 || last4 !== 1'b0) begin
      failures++; $display("FAIL mask_beat2 got bin=%0d last=%b exp 1/0", bin4, last4); end
    en4 = 4'b1101;
    step();
    checks++; if (valid4 !== 1'b1 || bin4 !== 2'd2 || last4 !== 1'b1) begin
      failures++; $display("FAIL mask_move got valid=%b bin=%0d last=%b exp 1/2/1", valid4, bin4, last4); end
    req4 = 4'b0000;
    step();
    checks++; if (valid4 !== 1'b0 || hot4 !== 4'b0 || last4 !== 1'b0) begin
      failures++; $display("FAIL drop_idle got valid=%b hot=%b last=%b exp 0/0000/0", valid4, hot4, last4); end
    checks++; if (bin4 !== 2'd2) begin
      failures++; $display("FAIL drop_bin_hold got=%0d exp=2", bin4); end
  endtask

  task automatic test_wrap_np2();
    int exp_bin[6] = '{4, 0, 4, 0, 4, 0};
    logic [4:0] exp_hot;
    do_reset();
    weight5 = 20'h33333;  // ignored in plain round-robin mode
    req5 = 5'b10001; en5 = 5'b11111; ready5 = 1; lock5 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_hot = 5'b00001 << exp_bin[i];
      checks++; if (valid5 !== 1'b1 || bin5 !== 3'(exp_bin[i]) || bin5 > 3'd4) begin
        failures++; $display("FAIL np2_bin beat=%0d got valid=%b bin=%0d exp 1/%0d", i, valid5, bin5, exp_bin[i]); end
      checks++; if (last5 !== 1'b1 || hot5 !== exp_hot) begin
        failures++; $display("FAIL np2_last_hot beat=%0d got last=%b hot=%b exp 1/%b", i, last5, hot5, exp_hot); end
    end
    req5 = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    weight4 = 16'h3000;  // w3=3
    req4 = 4'b1000; en4 = 4'b1111; ready4 = 1; lock4 = 0;
    step();
    step();
    checks++; if (valid4 !== 1'b1 || bin4 !== 2'd3 || last4 !== 1'b0) begin
      failures++; $display("FAIL rmid_pre got valid=%b bin=%0d last=%b exp 1/3/0", valid4, bin4, last4); end
    rst = 1; req4 = 4'b1111;
    step();
    checks++; if (valid4 !== 1'b0 || bin4 !== 2'd0 || hot4 !== 4'b0 || last4 !== 1'b0) begin
      failures++; $display("FAIL rmid_reset got valid=%b bin=%0d hot=%b last=%b exp 0/0/0000/0", valid4, bin4, hot4, last4); end
    rst = 0;
    step();
    checks++; if (valid4 !== 1'b1 || bin4 !== 2'd1) begin
      failures++; $display("FAIL rmid_first got valid=%b bin=%0d exp 1/1", valid4, bin4); end
  endtask

  initial begin
    clk = 0; rst = 1; checks = 0; failures = 0;
    req4 = '0; en4 = '0; weight4 = '0; lock4 = 0; ready4 = 0;
    req5 = '0; en5 = '0; weight5 = '0; lock5 = 0; ready5 = 0;
    test_reset();
    test_weighted_rotation();
    test_backpressure();
    test_lock();
    test_mask_drop();
    test_wrap_np2();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ldl_round_wrr.md
Name: ldl_round_wrr

Overview:
- Registered weighted round-robin arbiter with a valid/ready grant output; successor to the single-beat round-robin arbiter in the round library.
- Each grant holds for up to a per-requester weight of accepted beats, then rotates to the next active requester.
- Supports non-power-of-two requester counts, per-requester enable masking, and a lock input for multi-beat packets.
- Sits in front of shared resources: bus ports, FIFO write muxes, DMA channels.

Parameters:
- REQ_WIDTH, 8, number of requesters; 2..256, need not be a power of two.
- BIN_WIDTH, $clog2(REQ_WIDTH), width of the encoded grant index.
- WGT_WIDTH, 4, width of each per-requester weight field.
- MODE, 1, 1 = weighted; 0 = plain round-robin (weights ignored, every grant is one beat).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  REQ_WIDTH  request vector, level-sensitive.
- en  in  REQ_WIDTH  per-requester enable; 0 masks the requester out of new arbitration.
- weight  in  REQ_WIDTH*WGT_WIDTH  flat weights; field i = weight[i*WGT_WIDTH +: WGT_WIDTH].
- lock  in  1  sampled on a handshake cycle; 1 keeps the current grant regardless of weight.
- ready  in  1  consumer accepts the current grant.
- valid  out  1  grant valid (registered).
- hot  out  REQ_WIDTH  one-hot grant; all-zero when valid = 0.
- bin  out  BIN_WIDTH  encoded grant index (registered); holds its last value when idle.
- last  out  1  current beat is the final beat of this grant's weight budget.

Behaviour:
- Reset: valid = 0, bin = 0, hot = 0, last = 0. Internal beat counter cnt = 0; latched weight wq = 1.
- Update condition: state changes only when upd = ~valid | ready. When valid & ~ready, all state holds, even if req[bin] drops (no grant withdrawal).
- Effective weight: we(i) = 1 if MODE = 0 or weight field i = 0; otherwise the weight field.
- Keep rule: on upd with valid & ready & req[bin] & en[bin] & (lock | cnt + 1 < wq):
  - valid = 1, bin unchanged, cnt = cnt + 1.
  - Under lock, cnt saturates at its maximum value.
- Re-arbitrate (otherwise, on upd):
  - Candidates: c = req & en.
  - Search order: bin+1, bin+2, ... wrapping at REQ_WIDTH-1 to 0, with bin itself checked last. This applies whether or not valid was set.
  - First hit f: valid = 1, bin = f, cnt = 0, wq = we(f).
  - No hit: valid = 0; bin and cnt hold.
- Index range: indices >= REQ_WIDTH never appear on bin. Wrap uses modulo REQ_WIDTH, not 2^BIN_WIDTH.
- Outputs:
  - Latency from req rise to valid: 1 cycle.
  - hot = valid ? (1 << bin) : 0, decoded from registers.
  - last = valid & ~lock & (cnt + 1 >= wq), combinational from registers and lock.
- Simultaneous events:
  - en[bin] deasserting mid-grant ends the grant at the next handshake.
  - Weight changes take effect only at the next new grant.
- Reset mid-grant: the rst cycle overrides everything; valid = 0 the next cycle and arbitration restarts with bin = 0 (index 1 searched first).
- Fairness: with all requesters continuously active, each requester i receives exactly we(i) consecutive beats per rotation.

Decomposition:
- Package ldl_round_pkg:
  - constant MAX_REQ = 256.
  - function eff_weight(raw, mode).
  - function wrap_inc(idx, n).
- Sub-module ldl_round_pick: combinational rotating-priority picker.
  - Inputs: c[REQ_WIDTH], start index.
  - Outputs: hit, index.
  - Implemented as a double-width vector with priority encoding.
- Top level holds the counter, the latched weight and the handshake FSM:
  - IDLE: valid = 0.
  - GRANT: valid = 1, cnt < wq-1.
  - LAST: valid = 1, cnt = wq-1.
  - LOCKED: lock held through handshakes.
  - Transitions follow the keep and re-arbitrate rules above.

Test Plan:
- Weighted rotation: REQ_WIDTH = 4, req = 1111, en = 1111, weights {1,2,3,0}, ready = 1 constant -> grant sequence 1,1,2,2,2,3,0,1,1,... (index 0 weight 0 acts as 1; arbitration starts at index 1 after reset); last pulses on the final beat of each group.
- Backpressure: single req[2], weight 3, ready low for 5 cycles after the first grant -> valid, bin = 2 and cnt held; 3 accepted beats then re-grant of 2 with cnt = 0.
- Lock: req = 0011, weight[0] = 1, lock = 1 for 4 handshakes -> bin stays 0 for 4 beats with last = 0; after lock drops, the next beat rotates to bin = 1.
- Mask and drop: en[1] cleared while bin = 1 with weight 4 after beat 2 -> the grant moves to the next enabled requester on the following handshake; req = 0 -> valid = 0 and hot = 0 one cycle later.
- Non-power-of-two wrap: REQ_WIDTH = 5, MODE = 0, req = 10001 -> bin alternates 4,0,4,0 and never exceeds 4.
- Reset mid-grant: rst asserted while bin = 3 with cnt = 1 -> next cycle valid = 0, bin = 0; with req = 1111 the first grant after reset is bin = 1.
